// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: FSM states, control/status bit
// positions and default bus widths.
package dma_pkg;

  localparam int DMA_ADDR_W = 16;
  localparam int DMA_CNT_W  = 16;
  localparam int DMA_DATA_W = 16;

  // ctrl_in bit positions
  localparam int CTRL_GO       = 0;
  localparam int CTRL_BYTE     = 1;
  localparam int CTRL_IEN      = 2;
  localparam int CTRL_DONE_CLR = 3;

  // ctrl_out bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_BYTE = 1;
  localparam int STAT_IEN  = 2;
  localparam int STAT_DONE = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_lane_align.sv
// One-unit holding register between read return and write issue, plus the
// byte-lane steering from the source lane to the destination lane.
module dma_lane_align
  import dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_arrive,
  input  logic                  i_arriveLane,
  input  logic [DMA_DATA_W-1:0] i_rdata,
  input  logic                  i_take,
  input  logic                  i_byteMode,
  input  logic                  i_dstLane,
  output logic                  o_full,
  output logic [DMA_DATA_W-1:0] o_wdata
);

  logic [DMA_DATA_W-1:0] r_holdData;
  logic                  r_holdLane;
  logic                  r_full;
  logic [DMA_DATA_W-1:0] w_srcWord;
  logic                  w_srcLane;
  logic [7:0]            w_byte;

  // Returning data is only parked here when it cannot be written in the
  // cycle it arrives; otherwise it bypasses straight to the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_holdData <= '0;
      r_holdLane <= 1'b0;
      r_full     <= 1'b0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_arrive && !i_take) begin
      r_holdData <= i_rdata;
      r_holdLane <= i_arriveLane;
      r_full     <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  always_comb begin
    w_srcWord = r_full ? r_holdData : i_rdata;
    w_srcLane = r_full ? r_holdLane : i_arriveLane;
    w_byte    = w_srcLane ? w_srcWord[15:8] : w_srcWord[7:0];
    o_wdata   = w_srcWord;
    if (i_byteMode) begin
      o_wdata = i_dstLane ? {w_byte, 8'h00} : {8'h00, w_byte};
    end
  end

  assign o_full = r_full;

endmodule

// File: rtl/dma_engine.sv
// Memory-to-memory DMA bus initiator: copies COUNT bytes or words from SRC
// to DST over the split read/write bus, one unit per granted cycle.
module dma_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     src_in,
  input  logic [ADDR_W-1:0]     dst_in,
  input  logic [CNT_W-1:0]      count_in,
  input  logic [7:0]            ctrl_in,
  input  logic                  src_write,
  input  logic                  dst_write,
  input  logic                  count_write,
  input  logic                  ctrl_write,
  output logic [ADDR_W-1:0]     src_out,
  output logic [ADDR_W-1:0]     dst_out,
  output logic [CNT_W-1:0]      count_out,
  output logic [7:0]            ctrl_out,
  output logic                  done_int,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic [ADDR_W-1:0]     dread_addr,
  input  logic [DMA_DATA_W-1:0] dread_data,
  output logic [ADDR_W-1:0]     dwrite_addr,
  output logic [DMA_DATA_W-1:0] dwrite_data,
  output logic [1:0]            dwrite_en
);

  dma_state_t            r_state;
  dma_state_t            w_nextState;
  logic [ADDR_W-1:0]     r_src;
  logic [ADDR_W-1:0]     r_dst;
  logic [ADDR_W-1:0]     r_rdPtr;
  logic [ADDR_W-1:0]     r_lastRdAddr;
  logic [ADDR_W-1:0]     r_lastWrAddr;
  logic [DMA_DATA_W-1:0] r_lastWrData;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_rdLeft;
  logic                  r_byte;
  logic                  r_ien;
  logic                  r_pend;
  logic                  r_pendLane;

  logic                  w_busy;
  logic                  w_done;
  logic                  w_full;
  logic                  w_haveData;
  logic                  w_wrIssue;
  logic                  w_rdIssue;
  logic                  w_lastWr;
  logic                  w_abort;
  logic                  w_start;
  logic [ADDR_W-1:0]     w_step;
  logic [ADDR_W-1:0]     w_srcStart;
  logic [ADDR_W-1:0]     w_dstStart;
  logic [DMA_DATA_W-1:0] w_wdata;
  logic                  w_unused;

  assign w_busy     = (r_state == RUN) || (r_state == DRAIN);
  assign w_done     = (r_state == DONE);
  assign w_haveData = w_full || r_pend;
  assign w_wrIssue  = w_busy && bus_gnt && w_haveData;
  // A read may only issue if the unit it returns will find the holding slot empty.
  assign w_rdIssue  = (r_state == RUN) && bus_gnt && (r_rdLeft != '0) && (!w_haveData || w_wrIssue);
  assign w_lastWr   = w_wrIssue && (r_state == DRAIN) && (r_count == CNT_W'(1));
  assign w_abort    = ctrl_write && !ctrl_in[CTRL_GO] && w_busy && !w_lastWr;
  assign w_start    = !w_busy && (w_nextState == RUN);
  assign w_step     = r_byte ? ADDR_W'(1) : ADDR_W'(2);
  assign w_srcStart = ctrl_in[CTRL_BYTE] ? r_src : {r_src[ADDR_W-1:1], 1'b0};
  assign w_dstStart = ctrl_in[CTRL_BYTE] ? r_dst : {r_dst[ADDR_W-1:1], 1'b0};
  assign w_unused   = ^ctrl_in[7:4];

  // A control write landing on the final write is applied on top of DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (ctrl_write) begin
          if (ctrl_in[CTRL_GO]) begin
            w_nextState = (r_count != '0) ? RUN : DONE;
          end else if (ctrl_in[CTRL_DONE_CLR]) begin
            w_nextState = IDLE;
          end
        end
      end
      RUN: begin
        if (w_abort) begin
          w_nextState = IDLE;
        end else if (w_rdIssue && (r_rdLeft == CNT_W'(1))) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_lastWr) begin
          if (ctrl_write && !ctrl_in[CTRL_GO] && ctrl_in[CTRL_DONE_CLR]) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = DONE;
          end
        end else if (w_abort) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_rdPtr      <= '0;
      r_lastRdAddr <= '0;
      r_lastWrAddr <= '0;
      r_lastWrData <= '0;
      r_count      <= '0;
      r_rdLeft     <= '0;
      r_byte       <= 1'b0;
      r_ien        <= 1'b0;
      r_pend       <= 1'b0;
      r_pendLane   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (ctrl_write) begin
        r_ien <= ctrl_in[CTRL_IEN];
      end
      if (ctrl_write && !w_busy) begin
        r_byte <= ctrl_in[CTRL_BYTE];
      end
      if (w_start) begin
        r_src    <= w_srcStart;
        r_dst    <= w_dstStart;
        r_rdPtr  <= w_srcStart;
        r_rdLeft <= r_count;
      end else if (!w_busy) begin
        if (src_write)   r_src   <= src_in;
        if (dst_write)   r_dst   <= dst_in;
        if (count_write) r_count <= count_in;
      end else begin
        if (w_rdIssue) begin
          r_rdPtr      <= r_rdPtr + w_step;
          r_rdLeft     <= r_rdLeft - CNT_W'(1);
          r_lastRdAddr <= r_rdPtr;
        end
        // SRC/DST/COUNT advance on completed writes so an abort leaves them consistent.
        if (w_wrIssue) begin
          r_src        <= r_src + w_step;
          r_dst        <= r_dst + w_step;
          r_count      <= r_count - CNT_W'(1);
          r_lastWrAddr <= r_dst;
          r_lastWrData <= w_wdata;
        end
      end
      r_pend     <= w_rdIssue && !w_abort;
      r_pendLane <= r_rdPtr[0];
    end
  end

  dma_lane_align u_laneAlign (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_abort),
    .i_arrive    (r_pend),
    .i_arriveLane(r_pendLane),
    .i_rdata     (dread_data),
    .i_take      (w_wrIssue),
    .i_byteMode  (r_byte),
    .i_dstLane   (r_dst[0]),
    .o_full      (w_full),
    .o_wdata     (w_wdata)
  );

  assign dread_addr  = w_rdIssue ? r_rdPtr : r_lastRdAddr;
  assign dwrite_addr = w_wrIssue ? r_dst : r_lastWrAddr;
  assign dwrite_data = w_wrIssue ? w_wdata : r_lastWrData;
  assign dwrite_en   = w_wrIssue ? (r_byte ? 2'b01 : 2'b11) : 2'b00;

  assign src_out   = r_src;
  assign dst_out   = r_dst;
  assign count_out = r_count;
  assign ctrl_out  = {3'b000, w_unused & 1'b0, w_done, r_ien, r_byte, w_busy};
  assign done_int  = w_done && r_ien;
  assign bus_req   = w_busy;

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine with a byte-addressed memory
// model answering reads one cycle after the address.
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] src_in = '0;
  logic [15:0] dst_in = '0;
  logic [15:0] count_in = '0;
  logic [7:0]  ctrl_in = '0;
  logic        src_write = 1'b0;
  logic        dst_write = 1'b0;
  logic        count_write = 1'b0;
  logic        ctrl_write = 1'b0;
  logic [15:0] src_out;
  logic [15:0] dst_out;
  logic [15:0] count_out;
  logic [7:0]  ctrl_out;
  logic        done_int;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [15:0] dread_addr;
  logic [15:0] dread_data;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic [1:0]  dwrite_en;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;
  int goCyc = 1000000;
  int monRel;

  logic [7:0]  mem [0:65535];
  logic [15:0] memAddr = '0;

  logic [15:0] rdAt    [64];
  logic [15:0] wAddrAt [64];
  logic [15:0] wDataAt [64];
  logic [1:0]  enAt    [64];
  logic [7:0]  ctrlAt  [64];
  logic        reqAt   [64];
  logic [15:0] wAddrQ [$];
  logic [15:0] wDataQ [$];

  logic [15:0] expWord [4];

  dma_engine dut (
    .clk        (clk),
    .reset      (reset),
    .src_in     (src_in),
    .dst_in     (dst_in),
    .count_in   (count_in),
    .ctrl_in    (ctrl_in),
    .src_write  (src_write),
    .dst_write  (dst_write),
    .count_write(count_write),
    .ctrl_write (ctrl_write),
    .src_out    (src_out),
    .dst_out    (dst_out),
    .count_out  (count_out),
    .ctrl_out   (ctrl_out),
    .done_int   (done_int),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .dread_addr (dread_addr),
    .dread_data (dread_data),
    .dwrite_addr(dwrite_addr),
    .dwrite_data(dwrite_data),
    .dwrite_en  (dwrite_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    memAddr <= dread_addr;
  end

  assign dread_data = {mem[{memAddr[15:1], 1'b1}], mem[{memAddr[15:1], 1'b0}]};

  // Sample everything late in each cycle, indexed by cycle number after GO.
  always @(negedge clk) begin
    #3;
    monRel = cyc - goCyc + 1;
    if (monRel >= 1 && monRel < 64) begin
      rdAt[monRel]    = dread_addr;
      wAddrAt[monRel] = dwrite_addr;
      wDataAt[monRel] = dwrite_data;
      enAt[monRel]    = dwrite_en;
      ctrlAt[monRel]  = ctrl_out;
      reqAt[monRel]   = bus_req;
    end
    if (dwrite_en != 2'b00) begin
      wAddrQ.push_back(dwrite_addr);
      wDataQ.push_back(dwrite_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Loads SRC/DST/COUNT, then writes ctrl; returns inside cycle 1 of the run.
  task automatic applyStimulus(input logic [15:0] srcVal, input logic [15:0] dstVal,
                               input logic [15:0] cntVal, input logic [7:0] ctrlVal);
    goCyc = 1000000;
    wAddrQ.delete();
    wDataQ.delete();
    for (int i = 0; i < 64; i++) begin
      rdAt[i] = '0; wAddrAt[i] = '0; wDataAt[i] = '0;
      enAt[i] = '0; ctrlAt[i] = '0; reqAt[i] = 1'b0;
    end
    @(negedge clk);
    src_in = srcVal; dst_in = dstVal; count_in = cntVal;
    src_write = 1'b1; dst_write = 1'b1; count_write = 1'b1;
    @(negedge clk);
    src_write = 1'b0; dst_write = 1'b0; count_write = 1'b0;
    ctrl_in = ctrlVal; ctrl_write = 1'b1;
    @(posedge clk);
    #1;
    goCyc = cyc;
    ctrl_write = 1'b0;
  endtask

  task automatic ctrlWrite(input logic [7:0] v);
    @(negedge clk);
    ctrl_in = v; ctrl_write = 1'b1;
    @(negedge clk);
    ctrl_write = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int a = 0; a < 8; a++) mem[16'h0100 + a] = 8'h10 + 8'(a);
    expWord[0] = 16'h1110; expWord[1] = 16'h1312;
    expWord[2] = 16'h1514; expWord[3] = 16'h1716;

    runCycles(2);
    reset = 1'b0;
    #1;
    checkOutput("rst_ctrl", ctrl_out, 8'h00);
    checkOutput("rst_src", src_out, 16'h0000);
    checkOutput("rst_dst", dst_out, 16'h0000);
    checkOutput("rst_count", count_out, 16'h0000);
    checkOutput("rst_int", done_int, 1'b0);
    checkOutput("rst_req", bus_req, 1'b0);
    checkOutput("rst_en", dwrite_en, 2'b00);
    checkOutput("rst_raddr", dread_addr, 16'h0000);
    checkOutput("rst_waddr", dwrite_addr, 16'h0000);
    checkOutput("rst_wdata", dwrite_data, 16'h0000);

    // Word copy; a DST write mid-run must be ignored.
    applyStimulus(16'h0100, 16'h0200, 16'd4, 8'h01);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      dst_in = 16'hDEAD;
      dst_write = (k == 3);
    end
    dst_write = 1'b0;
    checkOutput("wc_req1", reqAt[1], 1'b1);
    checkOutput("wc_raddr1", rdAt[1], 16'h0100);
    checkOutput("wc_en1", enAt[1], 2'b00);
    for (int k = 2; k <= 5; k++) begin
      checkOutput($sformatf("wc_en%0d", k), enAt[k], 2'b11);
      checkOutput($sformatf("wc_waddr%0d", k), wAddrAt[k], 16'h0200 + 16'(2 * (k - 2)));
      checkOutput($sformatf("wc_wdata%0d", k), wDataAt[k], expWord[k - 2]);
    end
    checkOutput("wc_en6", enAt[6], 2'b00);
    checkOutput("wc_ctrl5", ctrlAt[5], 8'h01);
    checkOutput("wc_ctrl6", ctrlAt[6], 8'h08);
    checkOutput("wc_count", count_out, 16'h0000);
    checkOutput("wc_src", src_out, 16'h0108);
    checkOutput("wc_dst", dst_out, 16'h0208);

    // Abort after two of eight words.
    applyStimulus(16'h0700, 16'h0800, 16'd8, 8'h01);
    runCycles(3);
    @(negedge clk);
    bus_gnt = 1'b0; ctrl_in = 8'h00; ctrl_write = 1'b1;
    @(negedge clk);
    ctrl_write = 1'b0; bus_gnt = 1'b1;
    #1;
    checkOutput("ab_req", bus_req, 1'b0);
    checkOutput("ab_ctrl", ctrl_out, 8'h00);
    checkOutput("ab_count", count_out, 16'd6);
    checkOutput("ab_dst", dst_out, 16'h0804);
    checkOutput("ab_src", src_out, 16'h0704);
    runCycles(3);
    checkOutput("ab_nwrites", wAddrQ.size(), 2);

    // Byte from odd source lane to even destination lane.
    mem[16'h0100] = 8'h5C;
    mem[16'h0101] = 8'hAB;
    applyStimulus(16'h0101, 16'h0300, 16'd1, 8'h03);
    runCycles(4);
    checkOutput("by_raddr", rdAt[1], 16'h0101);
    checkOutput("by_en", enAt[2], 2'b01);
    checkOutput("by_waddr", wAddrAt[2], 16'h0300);
    checkOutput("by_wdata", wDataAt[2], 16'h00AB);
    checkOutput("by_nwrites", wAddrQ.size(), 1);
    checkOutput("by_ctrl", ctrl_out, 8'h0A);
    checkOutput("by_src", src_out, 16'h0102);
    checkOutput("by_dst", dst_out, 16'h0301);

    // Grant low for cycles 3..5 of a three-word copy.
    for (int a = 0; a < 6; a++) mem[16'h0500 + a] = 8'h31 + 8'(a);
    applyStimulus(16'h0500, 16'h0600, 16'd3, 8'h01);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus_gnt = !(k >= 3 && k <= 5);
    end
    bus_gnt = 1'b1;
    checkOutput("st_nwrites", wAddrQ.size(), 3);
    if (wAddrQ.size() == 3) begin
      checkOutput("st_waddr0", wAddrQ[0], 16'h0600);
      checkOutput("st_waddr1", wAddrQ[1], 16'h0602);
      checkOutput("st_waddr2", wAddrQ[2], 16'h0604);
      checkOutput("st_wdata0", wDataQ[0], 16'h3231);
      checkOutput("st_wdata1", wDataQ[1], 16'h3433);
      checkOutput("st_wdata2", wDataQ[2], 16'h3635);
    end
    checkOutput("st_en4", enAt[4], 2'b00);
    checkOutput("st_en6", enAt[6], 2'b11);
    checkOutput("st_ctrl", ctrl_out, 8'h08);

    // Source address wraps from 0xFFFE to 0x0000.
    mem[16'hFFFE] = 8'h21; mem[16'hFFFF] = 8'h43;
    mem[16'h0000] = 8'h65; mem[16'h0001] = 8'h87;
    applyStimulus(16'hFFFE, 16'h0400, 16'd2, 8'h01);
    runCycles(5);
    checkOutput("wr_raddr1", rdAt[1], 16'hFFFE);
    checkOutput("wr_raddr2", rdAt[2], 16'h0000);
    checkOutput("wr_nwrites", wAddrQ.size(), 2);
    if (wAddrQ.size() == 2) begin
      checkOutput("wr_wdata0", wDataQ[0], 16'h4321);
      checkOutput("wr_wdata1", wDataQ[1], 16'h8765);
      checkOutput("wr_waddr1", wAddrQ[1], 16'h0402);
    end
    checkOutput("wr_src", src_out, 16'h0002);

    // GO with COUNT==0 and IEN set.
    ctrlWrite(8'h08);
    checkOutput("z_idle", ctrl_out, 8'h00);
    applyStimulus(16'h0900, 16'h0A00, 16'd0, 8'h05);
    checkOutput("z_int", done_int, 1'b1);
    checkOutput("z_ctrl", ctrl_out, 8'h0C);
    checkOutput("z_req", bus_req, 1'b0);
    runCycles(3);
    checkOutput("z_nwrites", wAddrQ.size(), 0);
    ctrlWrite(8'h0C);
    #1;
    checkOutput("z_clr_int", done_int, 1'b0);
    checkOutput("z_clr_ctrl", ctrl_out, 8'h04);

    // Asynchronous reset while a write is on the bus.
    applyStimulus(16'h0100, 16'h0B00, 16'd4, 8'h01);
    runCycles(2);
    #1;
    checkOutput("rm_pre_en", dwrite_en, 2'b11);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rm_en", dwrite_en, 2'b00);
    checkOutput("rm_req", bus_req, 1'b0);
    checkOutput("rm_ctrl", ctrl_out, 8'h00);
    checkOutput("rm_count", count_out, 16'h0000);
    checkOutput("rm_src", src_out, 16'h0000);
    checkOutput("rm_waddr", dwrite_addr, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    runCycles(2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
